// File: rtl/dom_indep_mul_dup_pkg.sv
// Shared index helpers for the duplicated DOM-independent masked AND.
// Pair, cross-term and share-slice arithmetic lives here so both banks agree.
package dom_indep_mul_dup_pkg;

  function automatic int n_rand(input int order);
    return ((order + 1) * order) / 2;
  endfunction

  // Lexicographic index of the unordered pair {i,j}; (j,i) maps to the same word.
  function automatic int pair_idx(input int i, input int j, input int n);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * n - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  // Dense slot of ordered cross term q_ij (i != j) with the diagonal skipped.
  function automatic int cross_idx(input int i, input int j, input int n);
    return i * (n - 1) + ((j < i) ? j : j - 1);
  endfunction

  function automatic int share_lsb(input int i, input int width);
    return i * width;
  endfunction

endpackage

// File: rtl/dom_indep_mul_dup_core.sv
// One resharing bank: stage-1 inner/cross product registers and the stage-2
// compression XOR trees (combinational, registered by the top level).
module dom_indep_mul_dup_core
  import dom_indep_mul_dup_pkg::*;
#(
  parameter int ORDER = 1,
  parameter int WIDTH = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cap,
  input  logic [(ORDER+1)*WIDTH-1:0]        in_a,
  input  logic [(ORDER+1)*WIDTH-1:0]        in_b,
  input  logic [n_rand(ORDER)*WIDTH-1:0]    in_r,
  output logic [(ORDER+1)*WIDTH-1:0]        c_next
);

  localparam int N  = ORDER + 1;
  localparam int NQ = N * (N - 1);

  logic [N*WIDTH-1:0]  p_q;
  logic [NQ*WIDTH-1:0] q_q;
  logic [WIDTH-1:0]    acc;

  // Inner terms are registered with the cross terms so every share settles together.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
      q_q <= '0;
    end else if (cap) begin
      for (int i = 0; i < N; i++) begin
        p_q[share_lsb(i, WIDTH) +: WIDTH] <=
          in_a[share_lsb(i, WIDTH) +: WIDTH] & in_b[share_lsb(i, WIDTH) +: WIDTH];
        for (int j = 0; j < N; j++) begin
          if (j != i) begin
            q_q[share_lsb(cross_idx(i, j, N), WIDTH) +: WIDTH] <=
              (in_a[share_lsb(i, WIDTH) +: WIDTH] & in_b[share_lsb(j, WIDTH) +: WIDTH])
              ^ in_r[share_lsb(pair_idx(i, j, N), WIDTH) +: WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    c_next = '0;
    acc    = '0;
    for (int i = 0; i < N; i++) begin
      acc = p_q[share_lsb(i, WIDTH) +: WIDTH];
      for (int j = 0; j < N; j++) begin
        if (j != i) begin
          acc = acc ^ q_q[share_lsb(cross_idx(i, j, N), WIDTH) +: WIDTH];
        end
      end
      c_next[share_lsb(i, WIDTH) +: WIDTH] = acc;
    end
  end

endmodule

// File: rtl/dom_indep_mul_dup.sv
// d-th order DOM-independent masked AND with a fully duplicated resharing bank;
// the banks are compared at stage 2 to raise a fault pulse, sticky flag and count.
module dom_indep_mul_dup
  import dom_indep_mul_dup_pkg::*;
#(
  parameter int ORDER  = 1,
  parameter int WIDTH  = 1,
  parameter int FCNT_W = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [(ORDER+1)*WIDTH-1:0]        in_a,
  input  logic [(ORDER+1)*WIDTH-1:0]        in_b,
  input  logic [n_rand(ORDER)*WIDTH-1:0]    in_r,
  input  logic                              fault_clr,
  output logic                              out_valid,
  output logic [(ORDER+1)*WIDTH-1:0]        out_c,
  output logic                              fault,
  output logic                              fault_sticky,
  output logic [FCNT_W-1:0]                 fault_cnt
);

  localparam int N = ORDER + 1;
  localparam logic [FCNT_W-1:0] CNT_MAX = '1;

  // Valid semantics: in_valid qualifies in_a/in_b/in_r for exactly one cycle;
  // there is no ready, every accepted op emerges with out_valid two cycles later.
  logic               v1;
  logic [N*WIDTH-1:0] c_pri;
  logic [N*WIDTH-1:0] c_dup;

  dom_indep_mul_dup_core #(.ORDER(ORDER), .WIDTH(WIDTH)) u_pri (
    .clk    (clk),
    .rst    (rst),
    .cap    (in_valid),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_r   (in_r),
    .c_next (c_pri)
  );

  // The duplicate must survive synthesis as a separate bank or the check is void.
  (* keep_hierarchy = "yes", dont_touch = "true" *)
  dom_indep_mul_dup_core #(.ORDER(ORDER), .WIDTH(WIDTH)) u_dup (
    .clk    (clk),
    .rst    (rst),
    .cap    (in_valid),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_r   (in_r),
    .c_next (c_dup)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
      out_c     <= '0;
      fault     <= 1'b0;
    end else begin
      v1        <= in_valid;
      out_valid <= v1;
      fault     <= v1 && (c_pri != c_dup);
      if (v1) begin
        out_c <= c_pri;
      end
    end
  end

  // Clear has priority over a coincident pulse, which is then dropped.
  always_ff @(posedge clk) begin
    if (rst || fault_clr) begin
      fault_sticky <= 1'b0;
      fault_cnt    <= '0;
    end else if (fault) begin
      fault_sticky <= 1'b1;
      if (fault_cnt != CNT_MAX) begin
        fault_cnt <= fault_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dom_indep_mul_dup.sv
// Directed bench: a first-order 1-bit instance (basic op, fault injection,
// counter saturation/clear) and a second-order 4-bit instance (stream, bubbles).
module tb_dom_indep_mul_dup;

  logic clk;
  logic rst;

  // dut1: ORDER=1, WIDTH=1, FCNT_W=2
  logic       v1, clr1, ov1, f1, st1;
  logic [1:0] a1, b1, oc1, cnt1;
  logic [0:0] r1;

  // dut2: ORDER=2, WIDTH=4, FCNT_W=8
  logic        v2, clr2, ov2, f2, st2;
  logic [11:0] a2, b2, r2, oc2;
  logic [7:0]  cnt2;

  logic [1:0] force_val;
  int n_checks;
  int n_pass;

  logic [3:0] exp_q[$];

  dom_indep_mul_dup #(.ORDER(1), .WIDTH(1), .FCNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_a(a1), .in_b(b1), .in_r(r1),
    .fault_clr(clr1), .out_valid(ov1), .out_c(oc1), .fault(f1),
    .fault_sticky(st1), .fault_cnt(cnt1)
  );

  dom_indep_mul_dup #(.ORDER(2), .WIDTH(4), .FCNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_a(a2), .in_b(b2), .in_r(r2),
    .fault_clr(clr2), .out_valid(ov2), .out_c(oc2), .fault(f2),
    .fault_sticky(st2), .fault_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rec(input logic [11:0] x);
    return x[3:0] ^ x[7:4] ^ x[11:8];
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (ov1 !== 1'b0)   $display("FAIL rst_ov1: got %b want 0", ov1);   else n_pass++;
    n_checks++; if (f1 !== 1'b0)    $display("FAIL rst_f1: got %b want 0", f1);     else n_pass++;
    n_checks++; if (st1 !== 1'b0)   $display("FAIL rst_st1: got %b want 0", st1);   else n_pass++;
    n_checks++; if (cnt1 !== 2'd0)  $display("FAIL rst_cnt1: got %h want 0", cnt1); else n_pass++;
    n_checks++; if (oc1 !== 2'b00)  $display("FAIL rst_oc1: got %h want 0", oc1);   else n_pass++;
    n_checks++; if (ov2 !== 1'b0)   $display("FAIL rst_ov2: got %b want 0", ov2);   else n_pass++;
    n_checks++; if (f2 !== 1'b0)    $display("FAIL rst_f2: got %b want 0", f2);     else n_pass++;
    n_checks++; if (st2 !== 1'b0)   $display("FAIL rst_st2: got %b want 0", st2);   else n_pass++;
    n_checks++; if (cnt2 !== 8'd0)  $display("FAIL rst_cnt2: got %h want 0", cnt2); else n_pass++;
    n_checks++; if (oc2 !== 12'h0)  $display("FAIL rst_oc2: got %h want 0", oc2);   else n_pass++;
  endtask

  // a=(1,0), b=(0,1), r=0: c0 = a0&b1 = 1, c1 = a1&b0 = 0
  task automatic test_basic();
    v1 = 1'b1; a1 = 2'b01; b1 = 2'b10; r1 = 1'b0;
    @(negedge clk);
    v1 = 1'b0; a1 = 2'b11; b1 = 2'b11; r1 = 1'b1;
    n_checks++; if (ov1 !== 1'b0)  $display("FAIL basic_early_ov: got %b want 0", ov1); else n_pass++;
    @(negedge clk);
    n_checks++; if (ov1 !== 1'b1)  $display("FAIL basic_ov: got %b want 1", ov1);       else n_pass++;
    n_checks++; if (oc1 !== 2'b01) $display("FAIL basic_oc: got %b want 01", oc1);     else n_pass++;
    n_checks++; if ((oc1[0] ^ oc1[1]) !== 1'b1) $display("FAIL basic_xor: got %b want 1", oc1[0] ^ oc1[1]); else n_pass++;
    n_checks++; if (f1 !== 1'b0)   $display("FAIL basic_fault: got %b want 0", f1);     else n_pass++;
    @(negedge clk);
    n_checks++; if (ov1 !== 1'b0)  $display("FAIL basic_ov_drop: got %b want 0", ov1);  else n_pass++;
    n_checks++; if (oc1 !== 2'b01) $display("FAIL basic_hold: got %b want 01", oc1);    else n_pass++;
  endtask

  // One op on dut1 with bit 0 of the duplicate q_01 flipped while in stage 1.
  task automatic run_fault_op(input logic [1:0] a, input logic [1:0] b, input logic r,
                              input logic clr_on_pulse,
                              output logic ov, output logic flt, output logic stk,
                              output logic [1:0] oc);
    force_val = {(a[1] & b[0]) ^ r, ~((a[0] & b[1]) ^ r)};
    v1 = 1'b1; a1 = a; b1 = b; r1 = r;
    @(negedge clk);
    v1 = 1'b0;
    force dut1.u_dup.q_q = force_val;
    @(negedge clk);
    ov = ov1; flt = f1; stk = st1; oc = oc1;
    release dut1.u_dup.q_q;
    clr1 = clr_on_pulse;
    @(negedge clk);
    clr1 = 1'b0;
  endtask

  // a=b=(1,1), r=1: primary c0 = 1^(1^1) = 1, c1 = 1^(1^1) = 1
  task automatic test_fault();
    logic ov, flt, stk;
    logic [1:0] oc;
    run_fault_op(2'b11, 2'b11, 1'b1, 1'b0, ov, flt, stk, oc);
    n_checks++; if (ov !== 1'b1)   $display("FAIL inj_ov: got %b want 1", ov);         else n_pass++;
    n_checks++; if (flt !== 1'b1)  $display("FAIL inj_pulse: got %b want 1", flt);     else n_pass++;
    n_checks++; if (stk !== 1'b0)  $display("FAIL inj_sticky_early: got %b want 0", stk); else n_pass++;
    n_checks++; if (oc !== 2'b11)  $display("FAIL inj_oc: got %b want 11", oc);        else n_pass++;
    n_checks++; if (f1 !== 1'b0)   $display("FAIL inj_pulse_len: got %b want 0", f1);  else n_pass++;
    n_checks++; if (st1 !== 1'b1)  $display("FAIL inj_sticky: got %b want 1", st1);    else n_pass++;
    n_checks++; if (cnt1 !== 2'd1) $display("FAIL inj_cnt: got %0d want 1", cnt1);     else n_pass++;
  endtask

  task automatic test_saturate();
    logic ov, flt, stk;
    logic [1:0] oc;
    logic [1:0] exp_cnt [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 4; k++) begin
      run_fault_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'b0, ov, flt, stk, oc);
      n_checks++; if (flt !== 1'b1) $display("FAIL sat_pulse%0d: got %b want 1", k, flt); else n_pass++;
      n_checks++; if (cnt1 !== exp_cnt[k]) $display("FAIL sat_cnt%0d: got %0d want %0d", k, cnt1, exp_cnt[k]); else n_pass++;
    end
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    n_checks++; if (cnt1 !== 2'd0) $display("FAIL clr_cnt: got %0d want 0", cnt1);   else n_pass++;
    n_checks++; if (st1 !== 1'b0)  $display("FAIL clr_sticky: got %b want 0", st1);  else n_pass++;
    run_fault_op(2'b10, 2'b01, 1'b0, 1'b1, ov, flt, stk, oc);
    n_checks++; if (flt !== 1'b1)  $display("FAIL clrhit_pulse: got %b want 1", flt);  else n_pass++;
    n_checks++; if (cnt1 !== 2'd0) $display("FAIL clrhit_cnt: got %0d want 0", cnt1);  else n_pass++;
    n_checks++; if (st1 !== 1'b0)  $display("FAIL clrhit_sticky: got %b want 0", st1); else n_pass++;
    run_fault_op(2'b01, 2'b11, 1'b1, 1'b0, ov, flt, stk, oc);
    n_checks++; if (cnt1 !== 2'd1) $display("FAIL recount_cnt: got %0d want 1", cnt1); else n_pass++;
    n_checks++; if (st1 !== 1'b1)  $display("FAIL recount_sticky: got %b want 1", st1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] vh;
    logic [3:0] e;
    int n_out;
    vh = 2'b00;
    n_out = 0;
    for (int n = 0; n < 1003; n++) begin
      n_checks++; if (ov2 !== vh[1]) $display("FAIL b2b_ov@%0d: got %b want %b", n, ov2, vh[1]); else n_pass++;
      n_checks++; if (f2 !== 1'b0) $display("FAIL b2b_fault@%0d: got %b want 0", n, f2); else n_pass++;
      if (ov2 === 1'b1) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++; $display("FAIL b2b_underflow@%0d: got extra output want none", n);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if (rec(oc2) !== e) $display("FAIL b2b_data@%0d: got %h want %h", n, rec(oc2), e); else n_pass++;
        end
      end
      v2 = (n < 1000);
      vh = {vh[0], v2};
      a2 = 12'($urandom_range(0, 4095));
      b2 = 12'($urandom_range(0, 4095));
      r2 = 12'($urandom_range(0, 4095));
      if (v2) exp_q.push_back(rec(a2) & rec(b2));
      @(negedge clk);
    end
    n_checks++; if (n_out != 1000) $display("FAIL b2b_count: got %0d want 1000", n_out); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); else n_pass++;
  endtask

  // Ops A, B, C with hand-reduced expectations: A=C&F=C, B=F&0=0, C=A&C=8.
  task automatic test_bubble();
    logic        pat   [7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [11:0] ta    [3]  = '{12'h5A3, 12'hFFF, 12'h7C1};
    logic [11:0] tb    [3]  = '{12'h0F0, 12'h123, 12'h936};
    logic [11:0] tr    [3]  = '{12'hABC, 12'h5E1, 12'h3D7};
    logic [3:0]  texp  [3]  = '{4'hC, 4'h0, 4'h8};
    logic [11:0] held;
    int op_in, op_out;
    op_in = 0;
    op_out = 0;
    held = oc2;
    for (int n = 0; n < 9; n++) begin
      if (n >= 2) begin
        n_checks++; if (ov2 !== pat[n-2]) $display("FAIL bub_ov@%0d: got %b want %b", n, ov2, pat[n-2]); else n_pass++;
        if (pat[n-2]) begin
          n_checks++; if (rec(oc2) !== texp[op_out]) $display("FAIL bub_data%0d: got %h want %h", op_out, rec(oc2), texp[op_out]); else n_pass++;
          op_out++;
          held = oc2;
        end else begin
          n_checks++; if (oc2 !== held) $display("FAIL bub_hold@%0d: got %h want %h", n, oc2, held); else n_pass++;
        end
      end
      if (n < 7 && pat[n]) begin
        v2 = 1'b1; a2 = ta[op_in]; b2 = tb[op_in]; r2 = tr[op_in];
        op_in++;
      end else begin
        v2 = 1'b0; a2 = 12'($urandom_range(0, 4095)); b2 = 12'($urandom_range(0, 4095));
        r2 = 12'($urandom_range(0, 4095));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    v1 = 1'b1; a1 = 2'b11; b1 = 2'b11; r1 = 1'b0;
    v2 = 1'b1; a2 = 12'h5A3; b2 = 12'h0F0; r2 = 12'h111;
    @(negedge clk);
    v1 = 1'b0; v2 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (ov1 !== 1'b0)  $display("FAIL mid_ov1: got %b want 0", ov1);   else n_pass++;
    n_checks++; if (oc1 !== 2'b00) $display("FAIL mid_oc1: got %b want 0", oc1);   else n_pass++;
    n_checks++; if (st1 !== 1'b0)  $display("FAIL mid_st1: got %b want 0", st1);   else n_pass++;
    n_checks++; if (cnt1 !== 2'd0) $display("FAIL mid_cnt1: got %0d want 0", cnt1); else n_pass++;
    n_checks++; if (f1 !== 1'b0)   $display("FAIL mid_f1: got %b want 0", f1);     else n_pass++;
    n_checks++; if (ov2 !== 1'b0)  $display("FAIL mid_ov2: got %b want 0", ov2);   else n_pass++;
    n_checks++; if (oc2 !== 12'h0) $display("FAIL mid_oc2: got %h want 0", oc2);   else n_pass++;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      n_checks++; if (ov1 !== 1'b0) $display("FAIL mid_late_ov1@%0d: got %b want 0", n, ov1); else n_pass++;
      n_checks++; if (ov2 !== 1'b0) $display("FAIL mid_late_ov2@%0d: got %b want 0", n, ov2); else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    force_val = 2'b00;
    rst = 1'b1;
    v1 = 1'b0; a1 = '0; b1 = '0; r1 = '0; clr1 = 1'b0;
    v2 = 1'b0; a2 = '0; b2 = '0; r2 = '0; clr2 = 1'b0;
    test_reset();
    test_basic();
    test_fault();
    test_saturate();
    test_back_to_back();
    test_bubble();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
